// File: rtl/wb_pkg.sv
// Shared types and encodings for the write-back/retire stage: retire record,
// halt-trigger encoding, write-back source codes and the stage FSM states.
package wb_pkg;

    localparam logic [31:0] EBREAK_ENC = 32'h0010_0073;

    // Write-back source select codes: 0 means no write data, k selects source k-1
    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_LSU  = 2'd1;
    localparam logic [1:0] WB_EXU  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } retire_rec_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } wb_state_e;

endpackage

// File: rtl/retire_fifo.sv
// Synchronous FIFO holding retire records; extra pointer bit distinguishes full from empty.
module retire_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW:0]   r_wp;
    logic [PW:0]   r_rp;
    logic          w_do_push;
    logic          w_do_pop;

    assign count     = r_wp - r_rp;
    assign empty     = (r_wp == r_rp);
    assign full      = (count == (PW+1)'(DEPTH));
    assign head_data = r_mem[r_rp[PW-1:0]];

    // A pop frees the slot in the same cycle, so a push while full is legal alongside it
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_retire_unit.sv
// Write-back/retire stage: selects write-back data, drives regfile and forwarding,
// queues {pc,inst} retire records and runs the ebreak drain-then-halt sequence.
module wb_retire_unit
    import wb_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_SRC     = 2,
    parameter int          SEL_W       = 2,
    parameter int          REG_AW      = 5,
    parameter int          TRC_DEPTH   = 4,
    parameter logic [31:0] EBREAK_INST = EBREAK_ENC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_inst,
    input  logic [SEL_W-1:0]        in_wb_sel,
    input  logic [NUM_SRC*XLEN-1:0] in_src_data,
    input  logic                    in_rd_ena,
    input  logic [REG_AW-1:0]       in_rd_addr,
    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    fwd_valid,
    output logic [REG_AW-1:0]       fwd_addr,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    trc_valid,
    input  logic                    trc_ready,
    output logic [XLEN-1:0]         trc_pc,
    output logic [31:0]             trc_inst,
    output logic                    halted,
    output logic [XLEN-1:0]         halt_pc,
    output logic [1:0]              dbg_state
);

    localparam int PW = $clog2(TRC_DEPTH);
    localparam int RW = XLEN + 32;

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    logic            r_stage_v;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_wdata;
    logic            r_rd_ena;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0] r_halt_pc;

    logic [XLEN-1:0] w_sel_data;
    logic            w_fire;
    logic            w_is_ebreak;
    logic [PW+1:0]   w_occ;
    logic [RW-1:0]   w_head;
    logic            w_full;
    logic            w_empty;
    logic [PW:0]     w_cnt;

    // Handshake: an instruction transfers on a cycle where in_valid and in_ready are both high;
    // in_ready depends only on registered state, never on in_valid.
    assign w_occ       = {1'b0, w_cnt} + (PW+2)'(r_stage_v);
    assign in_ready    = (r_state == ST_RUN) & ~w_full & (w_occ < (PW+2)'(TRC_DEPTH));
    assign w_fire      = in_valid & in_ready;
    assign w_is_ebreak = (in_inst == EBREAK_INST);

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_wb_sel != SEL_W'(WB_NONE) && in_wb_sel == SEL_W'(k + 1))
                w_sel_data = in_src_data[k*XLEN +: XLEN];
        end
    end

    // Stage register lives one cycle: cleared or reloaded every edge, so it never stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_v <= 1'b0;
            r_pc      <= '0;
            r_inst    <= '0;
            r_wdata   <= '0;
            r_rd_ena  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_stage_v <= w_fire;
            if (w_fire) begin
                r_pc      <= in_pc;
                r_inst    <= in_inst;
                r_wdata   <= w_sel_data;
                r_rd_ena  <= in_rd_ena;
                r_rd_addr <= in_rd_addr;
            end
        end
    end

    assign rf_we     = r_stage_v & r_rd_ena & (r_rd_addr != '0);
    assign rf_waddr  = r_rd_addr;
    assign rf_wdata  = r_wdata;
    assign fwd_valid = rf_we;
    assign fwd_addr  = r_rd_addr;
    assign fwd_data  = r_wdata;

    retire_fifo #(
        .DW    (RW),
        .DEPTH (TRC_DEPTH)
    ) u_retire_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_stage_v),
        .push_data ({r_pc, r_inst}),
        .pop       (trc_ready),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_cnt)
    );

    assign trc_valid = ~w_empty;
    assign trc_pc    = w_head[RW-1:32];
    assign trc_inst  = w_head[31:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_fire && w_is_ebreak) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!r_stage_v && w_empty) w_state_nxt = ST_HALTED;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                      r_halt_pc <= '0;
        else if (w_fire && w_is_ebreak) r_halt_pc <= in_pc;
    end

    assign halted    = (r_state == ST_HALTED);
    assign halt_pc   = r_halt_pc;
    assign dbg_state = r_state;

endmodule
